// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: key conditioning, IDLE/RUN/LAP/STOP FSM and tick prescaler.
// Define STOPWATCH_CTRL_DEBOUNCE_EN to enable the key debouncers.
module stopwatch_ctrl #(
  parameter int TICK_DIV     = 50000000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  output logic       tick,
  output logic       clr,
  output logic       running,
  output logic       freeze,
  output logic [1:0] state
);

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int DB_N = DEBOUNCE_CYC;
`else
  // Bypass: accept any changed sample at once; DEBOUNCE_CYC has no effect.
  localparam int DB_N = (DEBOUNCE_CYC > 0) ? 1 : 1;
`endif

  localparam int CW = (DB_N > 1) ? $clog2(DB_N) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_N - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_e;

  logic [1:0]         keys;
  logic [1:0]         s1_q, s2_q;
  logic [1:0]         db_q, prev_q;
  logic [1:0]         arm_q, vld_q;
  logic [1:0][CW-1:0] cnt_q;
  logic [1:0]         press;
  logic               s_p, l_p;

  state_e         state_q;
  logic           tick_q, clr_q;
  logic           run_q, frz_q;
  logic [PW-1:0]  psc_q;

  assign keys = {key_lap_n, key_start_n};

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      s1_q   <= '1;
      s2_q   <= '1;
      db_q   <= '1;
      prev_q <= '1;
      arm_q  <= '0;
      vld_q  <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= keys;
      s2_q   <= s1_q;
      prev_q <= db_q;
      vld_q  <= {vld_q[0], 1'b1};
      for (int k = 0; k < 2; k++) begin
        // Arm only after a genuine released sample: keys held through reset stay quiet.
        arm_q[k] <= arm_q[k] | (vld_q[1] & s2_q[k] & db_q[k]);
        if (s2_q[k] == db_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == DB_LAST) begin
          db_q[k]  <= s2_q[k];
          cnt_q[k] <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign press = prev_q & ~db_q & arm_q;
  assign s_p   = press[0];
  assign l_p   = press[1];

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      run_q   <= 1'b0;
      frz_q   <= 1'b0;
      psc_q   <= '0;
    end else begin
      tick_q <= run_q && (psc_q == P_LAST);
      clr_q  <= 1'b0;
      if (run_q)
        psc_q <= (psc_q == P_LAST) ? '0 : psc_q + 1'b1;
      else if (state_q == IDLE)
        psc_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (s_p) begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end else if (l_p) begin
            clr_q   <= 1'b1;
          end
        end
        RUN: begin
          if (s_p) begin
            state_q <= STOP;
            run_q   <= 1'b0;
          end else if (l_p) begin
            state_q <= LAP;
            frz_q   <= 1'b1;
          end
        end
        LAP: begin
          if (s_p) begin
            state_q <= STOP;
            run_q   <= 1'b0;
            frz_q   <= 1'b0;
          end else if (l_p) begin
            state_q <= RUN;
            frz_q   <= 1'b0;
          end
        end
        STOP: begin
          if (s_p) begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end else if (l_p) begin
            state_q <= IDLE;
            clr_q   <= 1'b1;
            psc_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tick    = tick_q;
  assign clr     = clr_q;
  assign running = run_q;
  assign freeze  = frz_q;
  assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed vector table plus tick/latency/reset sequences.
// Expected key latency follows STOPWATCH_CTRL_DEBOUNCE_EN.
module tb_stopwatch_ctrl;
  localparam int TD = 4;
  localparam int DC = 3;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DEB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic       ks = 1'b1;
  logic       kl = 1'b1;
  logic       tick, clr, running, freeze;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int r = 0;

  typedef struct {
    bit         s;
    bit         l;
    logic [1:0] st;
    bit         run;
    bit         frz;
    bit         clr;
  } vec_t;

  vec_t tbl[12];

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYC(DC)) dut (
    .clk(clk), .aclr(aclr),
    .key_start_n(ks), .key_lap_n(kl),
    .tick(tick), .clr(clr), .running(running),
    .freeze(freeze), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    r++;
  endtask

  task automatic press(input bit s, input bit l);
    ks = ~s;
    kl = ~l;
    repeat (LAT + 1) step();
  endtask

  task automatic release_keys();
    ks = 1'b1;
    kl = 1'b1;
    repeat (LAT + 2) step();
  endtask

  task automatic do_reset();
    aclr = 1'b0;
    ks = 1'b1;
    kl = 1'b1;
    repeat (2) step();
    aclr = 1'b1;
    repeat (5) step();
  endtask

  initial begin
    int w;
    int n;
    tbl[0]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};

    #3;
    chk("rst_state", state, 2'b00);
    chk("rst_tick", tick, 0);
    chk("rst_clr", clr, 0);
    chk("rst_running", running, 0);
    chk("rst_freeze", freeze, 0);

    // Start press latency and tick spacing from IDLE
    do_reset();
    ks = 1'b0;
    repeat (LAT) step();
    chk("lat_pre_state", state, 2'b00);
    step();
    chk("lat_state", state, 2'b01);
    chk("lat_running", running, 1);
    r = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("run_tick_%0d", i), tick, (i % TD == 0) ? 1 : 0);
    end
    release_keys();

    // Stop with prescaler at 2, resume: first tick one cycle later
    w = ((2 - r - LAT) % TD + TD) % TD;
    repeat (w) step();
    press(1'b1, 1'b0);
    chk("stop_state", state, 2'b11);
    chk("stop_tick", tick, 0);
    ks = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      chk("stop_no_tick", tick, 0);
    end
    press(1'b1, 1'b0);
    chk("resume_state", state, 2'b01);
    chk("resume_tick0", tick, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("resume_tick_%0d", i), tick, (i == 1 || i == 5) ? 1 : 0);
    end
    release_keys();

    // Ticks continue in LAP while frozen
    press(1'b0, 1'b1);
    chk("lap_state", state, 2'b10);
    kl = 1'b1;
    n = 0;
    repeat (8) begin
      step();
      if (tick) n++;
    end
    chk("lap_ticks", n, 2);
    chk("lap_freeze", freeze, 1);
    release_keys();

    // LAP -> STOP, then lap in STOP clears for exactly one cycle
    press(1'b1, 1'b0);
    chk("lap_stop_freeze", freeze, 0);
    release_keys();
    press(1'b0, 1'b1);
    chk("clr_state", state, 2'b00);
    chk("clr_hi", clr, 1);
    step();
    chk("clr_lo", clr, 0);
    release_keys();

    // Vector table walk from IDLE
    for (int i = 0; i < 12; i++) begin
      press(tbl[i].s, tbl[i].l);
      chk($sformatf("v%0d_state", i), state, tbl[i].st);
      chk($sformatf("v%0d_running", i), running, tbl[i].run);
      chk($sformatf("v%0d_freeze", i), freeze, tbl[i].frz);
      chk($sformatf("v%0d_clr", i), clr, tbl[i].clr);
      release_keys();
    end

    // Asynchronous reset while running
    repeat (3) step();
    #2;
    aclr = 1'b0;
    #1;
    chk("arst_state", state, 2'b00);
    chk("arst_running", running, 0);
    chk("arst_tick", tick, 0);
    chk("arst_freeze", freeze, 0);
    chk("arst_clr", clr, 0);
    @(posedge clk);
    #3;
    aclr = 1'b1;
    repeat (5) step();

    // Two-cycle glitch
    ks = 1'b0;
    repeat (2) step();
    ks = 1'b1;
    repeat (12) step();
    chk("glitch_state", state, DEB ? 2'b00 : 2'b01);
    do_reset();

    // Key held through reset release, then released and pressed again
    ks = 1'b0;
    aclr = 1'b0;
    repeat (2) step();
    aclr = 1'b1;
    repeat (20) step();
    chk("held_state", state, 2'b00);
    release_keys();
    press(1'b1, 1'b0);
    chk("repress_state", state, 2'b01);
    release_keys();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
